// File: rtl/crossbar_route_checker.sv
// Route checker for the NxN barrel-shifter crossbar: collision mask, required shift, mapping error.
// Latency 2 cycles; valid/ready both sides, a stalled output holds and back-pressures through S1.
module crossbar_route_checker #(
    parameter  int N          = 8,
    parameter  int CNT_W      = 16,
    localparam int ROUTE_BITS = $clog2(N)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [N-1:0][ROUTE_BITS-1:0]   i_route,
    input  logic [N-1:0]                   i_output_enable,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [ROUTE_BITS-1:0]          o_out_shift,
    output logic                           o_out_collision,
    output logic [N-1:0]                   o_out_collision_mask,
    output logic                           o_out_mapping_error,
    output logic                           o_sticky_collision,
    output logic                           o_sticky_mapping,
    output logic [CNT_W-1:0]               o_err_count,
    input  logic                           i_clear_stats
);

    logic                           r_s1_valid;
    logic [N-1:0][ROUTE_BITS-1:0]   r_s1_route;
    logic [N-1:0]                   r_s1_en;
    logic [N-1:0]                   r_s1_mask;
    logic [ROUTE_BITS-1:0]          r_s1_first;

    logic                           r_out_valid;
    logic [ROUTE_BITS-1:0]          r_out_shift;
    logic                           r_out_coll;
    logic [N-1:0]                   r_out_mask;
    logic                           r_out_map;

    logic                           r_sticky_coll;
    logic                           r_sticky_map;
    logic [CNT_W-1:0]               r_err_count;

    logic                           w_s2_adv;
    logic                           w_s1_adv;
    logic [N-1:0]                   w_hit1;
    logic [N-1:0]                   w_mask;
    logic [ROUTE_BITS-1:0]          w_first;
    logic [ROUTE_BITS-1:0]          w_shift;
    logic                           w_map;
    logic                           w_consume;

    assign w_s2_adv   = !r_out_valid || i_out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign o_in_ready = w_s1_adv;
    assign w_consume  = r_out_valid && i_out_ready;

    // Stage 1: a destination seen a second time by an active input becomes a mask bit.
    always_comb begin
        w_hit1  = '0;
        w_mask  = '0;
        w_first = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (i_output_enable[i] && (i_route[i] == ROUTE_BITS'(j))) begin
                    w_mask[j] = w_mask[j] | w_hit1[j];
                    w_hit1[j] = 1'b1;
                end
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (i_output_enable[i]) begin
                w_first = ROUTE_BITS'(i);
            end
        end
    end

    // Stage 2: shift from the first active input; an empty request reports shift 0.
    always_comb begin
        w_shift = '0;
        w_map   = 1'b0;
        if (|r_s1_en) begin
            w_shift = r_s1_route[r_s1_first] - r_s1_first;
        end
        for (int i = 0; i < N; i++) begin
            if (r_s1_en[i] && (r_s1_route[i] != (ROUTE_BITS'(i) + w_shift))) begin
                w_map = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_route <= '0;
            r_s1_en    <= '0;
            r_s1_mask  <= '0;
            r_s1_first <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_route <= i_route;
                r_s1_en    <= i_output_enable;
                r_s1_mask  <= w_mask;
                r_s1_first <= w_first;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_shift <= '0;
            r_out_coll  <= 1'b0;
            r_out_mask  <= '0;
            r_out_map   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_shift <= w_shift;
                r_out_coll  <= |r_s1_mask;
                r_out_mask  <= r_s1_mask;
                r_out_map   <= w_map;
            end
        end
    end

    // Clear beats a simultaneous erroring handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky_coll <= 1'b0;
            r_sticky_map  <= 1'b0;
            r_err_count   <= '0;
        end else if (i_clear_stats) begin
            r_sticky_coll <= 1'b0;
            r_sticky_map  <= 1'b0;
            r_err_count   <= '0;
        end else if (w_consume) begin
            if (r_out_coll) begin
                r_sticky_coll <= 1'b1;
            end
            if (r_out_map) begin
                r_sticky_map <= 1'b1;
            end
            if ((r_out_coll || r_out_map) && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign o_out_valid          = r_out_valid;
    assign o_out_shift          = r_out_shift;
    assign o_out_collision      = r_out_coll;
    assign o_out_collision_mask = r_out_mask;
    assign o_out_mapping_error  = r_out_map;
    assign o_sticky_collision   = r_sticky_coll;
    assign o_sticky_mapping     = r_sticky_map;
    assign o_err_count          = r_err_count;

endmodule
